// File: rtl/slot_window_pkg.sv
// slot_window_pkg
//   Shared types and width helpers for the slot window counter.
//   mode_e    : per-slot counting mode (level = high samples, edge = rising edges)
//   cnt_width : bits needed to hold one slot count (0..slot_len)
//   sum_width : bits needed for a sum of win slot counts, overflow-free
package slot_window_pkg;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } mode_e;

  function automatic int cnt_width(input int slot_len);
    return $clog2(slot_len + 1);
  endfunction

  function automatic int sum_width(input int slot_len, input int win);
    return $clog2(slot_len + 1) + $clog2(win);
  endfunction

endpackage

// File: rtl/slot_window_ch.sv
// slot_window_ch
//   One channel of the sliding window: circular buffer of per-slot counts,
//   incremental running sum and registered threshold compare.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_clr          synchronous clear of running sum and flag
//     i_we           slot end: push i_new, retire the oldest count
//     i_wr_ptr       shared write pointer (also the oldest entry when full)
//     i_full         window holds WIN valid counts
//     i_new          count of the slot just completed
//     i_thresh       threshold for o_above
//     o_sum          sum of the last min(filled, WIN) counts
//     o_above        o_sum >= i_thresh, updated with o_sum
module slot_window_ch
  import slot_window_pkg::*;
#(
  parameter int WIN   = 250,
  parameter int CNT_W = cnt_width(20),
  parameter int SUM_W = sum_width(20, 250),
  parameter int PW    = $clog2(WIN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [PW-1:0]    i_wr_ptr,
  input  logic             i_full,
  input  logic [CNT_W-1:0] i_new,
  input  logic [SUM_W-1:0] i_thresh,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_above
);

  // Count history; no reset so it maps onto distributed RAM. Stale entries
  // after clr are masked by i_full until overwritten.
  logic [CNT_W-1:0] r_buf [WIN];
  logic [SUM_W-1:0] r_sum;
  logic             r_above;
  logic [CNT_W-1:0] w_old;
  logic [SUM_W-1:0] w_sum_nxt;

  // The entry about to be overwritten is the oldest one once the window is full.
  assign w_old     = i_full ? r_buf[i_wr_ptr] : '0;
  assign w_sum_nxt = r_sum + SUM_W'(i_new) - SUM_W'(w_old);

  always_ff @(posedge i_clk) begin
    if (i_we) r_buf[i_wr_ptr] <= i_new;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum   <= '0;
      r_above <= 1'b0;
    end else if (i_clr) begin
      r_sum   <= '0;
      r_above <= 1'b0;
    end else if (i_we) begin
      r_sum   <= w_sum_nxt;
      r_above <= (w_sum_nxt >= i_thresh);
    end
  end

  assign o_sum   = r_sum;
  assign o_above = r_above;

endmodule

// File: rtl/slot_window_counter.sv
// slot_window_counter
//   Multi-channel slot integrator. Each asynchronous din bit is synchronised,
//   counted (high samples or rising edges) over SLOT_LEN-cycle slots, and a
//   sliding sum over the last WIN slots is compared against thresh.
//   Ports:
//     CLOCK_200m  sole clock
//     rst         asynchronous active-high reset
//     en          advances slot timer and counting
//     clr         synchronous clear, priority over en
//     mode        0 = level count, 1 = rising-edge count (latched per slot)
//     din         asynchronous channel inputs
//     thresh      shared threshold
//     slot_cnt    last completed slot count per channel, channel 0 in LSBs
//     win_sum     sliding window sum per channel
//     above       win_sum >= thresh per channel
//     valid       one-cycle pulse when the outputs above update
//     win_full    sticky, WIN slots completed since rst/clr
module slot_window_counter
  import slot_window_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SLOT_LEN = 20,
  parameter int WIN      = 250,
  parameter int CNT_W    = cnt_width(SLOT_LEN),
  parameter int SUM_W    = sum_width(SLOT_LEN, WIN)
) (
  input  logic                CLOCK_200m,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                mode,
  input  logic [CH-1:0]       din,
  input  logic [SUM_W-1:0]    thresh,
  output logic [CH*CNT_W-1:0] slot_cnt,
  output logic [CH*SUM_W-1:0] win_sum,
  output logic [CH-1:0]       above,
  output logic                valid,
  output logic                win_full
);

  localparam int TW = $clog2(SLOT_LEN);
  localparam int PW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);

  logic [CH-1:0] r_s1, r_s2, r_prev;
  logic [TW-1:0] r_tcnt;
  mode_e         r_mode_q;
  logic [PW-1:0] r_wr_ptr;
  logic [FW-1:0] r_fill;
  logic          r_valid, r_win_full;

  logic          w_step, w_slot_end, w_full;
  mode_e         w_mode;
  logic [CH-1:0] w_sample;

  assign w_step     = en & ~clr;
  assign w_slot_end = w_step & (r_tcnt == TW'(SLOT_LEN - 1));
  assign w_full     = (r_fill == FW'(WIN));
  // The first cycle of a slot already uses the freshly latched mode.
  assign w_mode     = (r_tcnt == '0) ? mode_e'(mode) : r_mode_q;
  assign w_sample   = (w_mode == MODE_EDGE) ? (r_s2 & ~r_prev) : r_s2;

  // Synchronisers keep running while en is low.
  always_ff @(posedge CLOCK_200m or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  // prev only advances on counting cycles, so a rise during a pause is
  // seen exactly once when en returns.
  always_ff @(posedge CLOCK_200m or posedge rst) begin
    if (rst) begin
      r_tcnt     <= '0;
      r_mode_q   <= MODE_LEVEL;
      r_prev     <= '0;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_valid    <= 1'b0;
      r_win_full <= 1'b0;
    end else if (clr) begin
      r_tcnt     <= '0;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_valid    <= 1'b0;
      r_win_full <= 1'b0;
    end else begin
      r_valid <= w_slot_end;
      if (w_step) begin
        r_tcnt <= w_slot_end ? '0 : r_tcnt + TW'(1);
        r_prev <= r_s2;
        if (r_tcnt == '0) r_mode_q <= mode_e'(mode);
      end
      if (w_slot_end) begin
        r_wr_ptr <= (r_wr_ptr == PW'(WIN - 1)) ? '0 : r_wr_ptr + PW'(1);
        if (!w_full) r_fill <= r_fill + FW'(1);
        if (r_fill == FW'(WIN - 1)) r_win_full <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_acc, r_slot, w_new;

    // Count including the current cycle's sample, so slot end needs no extra cycle.
    assign w_new = r_acc + CNT_W'(w_sample[c]);

    always_ff @(posedge CLOCK_200m or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_slot <= '0;
      end else if (clr) begin
        r_acc  <= '0;
        r_slot <= '0;
      end else if (w_step) begin
        r_acc <= w_slot_end ? '0 : w_new;
        if (w_slot_end) r_slot <= w_new;
      end
    end

    slot_window_ch #(
      .WIN   (WIN),
      .CNT_W (CNT_W),
      .SUM_W (SUM_W),
      .PW    (PW)
    ) u_ch (
      .i_clk    (CLOCK_200m),
      .i_rst    (rst),
      .i_clr    (clr),
      .i_we     (w_slot_end),
      .i_wr_ptr (r_wr_ptr),
      .i_full   (w_full),
      .i_new    (w_new),
      .i_thresh (thresh),
      .o_sum    (win_sum[c*SUM_W +: SUM_W]),
      .o_above  (above[c])
    );

    assign slot_cnt[c*CNT_W +: CNT_W] = r_slot;
  end

  assign valid    = r_valid;
  assign win_full = r_win_full;

endmodule
